// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//   Shared definitions for the bit-serial adder family.
//   Holds the FSM state encoding so future adder variants (wider, pipelined,
//   multi-lane) agree on one encoding, plus the default operand width.
//   No ports: imported with `import serial_adder_pkg::*;`.
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    // Default operand/result width for the serial adder family.
    localparam int DEFAULT_WIDTH = 4;

    // Controller states. The encoding is fixed so that state values captured
    // in debug traces mean the same thing across every adder variant.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Majority of three bits: the carry function of a full adder.
    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/fa_cell.sv
// -----------------------------------------------------------------------------
// fa_cell
//   Single-bit combinational full adder. The serial adder reuses one instance
//   of this cell for every bit position; the carry register lives outside.
//   Ports:
//     a, b  in  1  addend bits
//     cin   in  1  carry in
//     s     out 1  sum bit
//     cout  out 1  carry out
// -----------------------------------------------------------------------------
module fa_cell
    import serial_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = maj3(a, b, cin);

endmodule

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial add/subtract unit. One full-adder cell is reused for WIDTH
//   clock cycles, LSB first, with a registered carry. Operations are launched
//   through a start/busy/done handshake; a new start is accepted in IDLE or on
//   the cycle done is high, giving one operation every WIDTH+1 cycles.
//   Subtraction is a + ~b + 1: B is inverted at load and the carry is seeded
//   with 1.
//   Parameters:
//     WIDTH     operand/result width, >= 2
//   Ports:
//     clk       in   1      rising-edge clock
//     rst       in   1      synchronous active-high reset
//     start     in   1      request, accepted only when busy=0
//     sub       in   1      0: a+b, 1: a-b (sampled at accept)
//     a, b      in   WIDTH  operands (sampled at accept)
//     busy      out  1      operation in progress
//     done      out  1      one-cycle pulse, results just became valid
//     sum       out  WIDTH  result modulo 2^WIDTH, held until next completion
//     cout      out  1      add: carry out; sub: 1 = no borrow
//     overflow  out  1      signed overflow
// -----------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    // Count value seen on the edge that processes the MSB.
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_e           state_r;
    state_e           state_nx_s;

    logic [WIDTH-1:0] a_sr_r;
    logic [WIDTH-1:0] b_sr_r;
    logic [WIDTH-1:0] res_sr_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;

    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             overflow_r;

    logic             load_s;
    logic             step_s;
    logic             finish_s;
    logic             fa_s_s;
    logic             fa_cout_s;

    // The single shared full-adder cell works on the current LSBs.
    fa_cell u_fa (
        .a    (a_sr_r[0]),
        .b    (b_sr_r[0]),
        .cin  (carry_r),
        .s    (fa_s_s),
        .cout (fa_cout_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic and datapath control strobes.
    always_comb begin
        state_nx_s = state_r;
        load_s     = 1'b0;
        step_s     = 1'b0;
        finish_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nx_s = ST_RUN;
                    load_s     = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // start is deliberately ignored here: no queueing.
                step_s = 1'b1;
                if (cnt_r == LAST_CNT) begin
                    state_nx_s = ST_DONE;
                    finish_s   = 1'b1;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_DONE: begin
                // Back-to-back launch is allowed on the done cycle.
                if (start) begin
                    state_nx_s = ST_RUN;
                    load_s     = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Operand/result shift registers, serial carry and bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr_r   <= {WIDTH{1'b0}};
            b_sr_r   <= {WIDTH{1'b0}};
            res_sr_r <= {WIDTH{1'b0}};
            carry_r  <= 1'b0;
            cnt_r    <= {CW{1'b0}};
        end else if (load_s) begin
            a_sr_r   <= a;
            b_sr_r   <= sub ? ~b : b;
            res_sr_r <= {WIDTH{1'b0}};
            carry_r  <= sub;
            cnt_r    <= {CW{1'b0}};
        end else if (step_s) begin
            // Result bits enter at the MSB so the LSB computed first ends up
            // at bit 0 after WIDTH shifts.
            a_sr_r   <= {1'b0, a_sr_r[WIDTH-1:1]};
            b_sr_r   <= {1'b0, b_sr_r[WIDTH-1:1]};
            res_sr_r <= {fa_s_s, res_sr_r[WIDTH-1:1]};
            carry_r  <= fa_cout_s;
            cnt_r    <= cnt_r + CNT_ONE;
        end else begin
            a_sr_r   <= a_sr_r;
            b_sr_r   <= b_sr_r;
            res_sr_r <= res_sr_r;
            carry_r  <= carry_r;
            cnt_r    <= cnt_r;
        end
    end

    // Registered handshake flags: busy follows RUN, done pulses after the MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_nx_s == ST_RUN);
            done_r <= finish_s;
        end
    end

    // Result capture on the MSB edge. While the MSB is processed, carry_r is
    // the carry into the MSB, so overflow is that XOR the carry out.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r      <= {WIDTH{1'b0}};
            cout_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else if (finish_s) begin
            sum_r      <= {fa_s_s, res_sr_r[WIDTH-1:1]};
            cout_r     <= fa_cout_s;
            overflow_r <= carry_r ^ fa_cout_s;
        end else begin
            sum_r      <= sum_r;
            cout_r     <= cout_r;
            overflow_r <= overflow_r;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign sum      = sum_r;
    assign cout     = cout_r;
    assign overflow = overflow_r;

endmodule
